// File: rtl/phase_detector.sv
// Counting phase detector for the Tiny-PLL loop: emits one signed, saturated error word per ref/fb edge pair.
// Optional: define PHASE_DET_DEADZONE_EN to report a one-cycle separation as 0 instead of +/-1.
module phase_detector #(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 31
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              ref_in,
  input  logic              fb_in,
  output logic signed [3:0] error_out,
  output logic              sample_en,
  output logic              cycle_slip
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_FB,
    WAIT_REF
  } state_t;

  localparam logic [7:0]        TIMEOUT_K = 8'(TIMEOUT);
  localparam logic signed [3:0] ERR_MAX   = 4'sd7;
  localparam logic signed [3:0] ERR_MIN   = -4'sd7;

  logic [SYNC_STAGES-1:0] ref_sync;
  logic [SYNC_STAGES-1:0] fb_dly;
  logic                   ref_prev;
  logic                   fb_prev;
  logic                   ref_edge;
  logic                   fb_edge;

  state_t     state;
  logic [7:0] n;
  logic [7:0] k;
  logic [3:0] mag;
  logic [3:0] err_lag;
  logic [3:0] err_lead;

  // fb_in is already in the clk domain; its delay line only matches the ref synchronizer latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ref_sync <= '0;
      fb_dly   <= '0;
      ref_prev <= 1'b0;
      fb_prev  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every stage take the previous stage's old value,
      // so the chain really is SYNC_STAGES flops deep rather than collapsing into one.
      ref_sync <= {ref_sync[SYNC_STAGES-2:0], ref_in};
      fb_dly   <= {fb_dly[SYNC_STAGES-2:0], fb_in};
      ref_prev <= ref_sync[SYNC_STAGES-1];
      fb_prev  <= fb_dly[SYNC_STAGES-1];
    end
  end

  assign ref_edge = ref_sync[SYNC_STAGES-1] & ~ref_prev;
  assign fb_edge  = fb_dly[SYNC_STAGES-1] & ~fb_prev;

  // k is the elapsed count including the current cycle, so a closing edge is always at k >= 1.
  assign k = n + 8'd1;

  function automatic logic [3:0] clamp_mag(input logic [7:0] kk);
    logic [3:0] m;
    m = (kk > 8'd7) ? 4'd7 : kk[3:0];
`ifdef PHASE_DET_DEADZONE_EN
    if (kk == 8'd1) m = 4'd0;
`endif
    return m;
  endfunction

  assign mag      = clamp_mag(k);
  assign err_lag  = mag;
  assign err_lead = 4'd0 - mag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      n          <= '0;
      error_out  <= '0;
      sample_en  <= 1'b0;
      cycle_slip <= 1'b0;
    end else begin
      // Strobes are single-cycle; error_out is deliberately not defaulted so it holds between strobes.
      sample_en  <= 1'b0;
      cycle_slip <= 1'b0;
      if (!enable) begin
        state <= IDLE;
        n     <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            n <= '0;
            if (ref_edge && fb_edge) begin
              error_out <= '0;
              sample_en <= 1'b1;
            end else if (ref_edge) begin
              state <= WAIT_FB;
            end else if (fb_edge) begin
              state <= WAIT_REF;
            end
          end
          WAIT_FB: begin
            if (fb_edge) begin
              error_out <= signed'(err_lag);
              sample_en <= 1'b1;
              n         <= '0;
              state     <= ref_edge ? WAIT_FB : IDLE;
            end else if (ref_edge) begin
              error_out  <= ERR_MAX;
              sample_en  <= 1'b1;
              cycle_slip <= 1'b1;
              n          <= '0;
            end else if (k == TIMEOUT_K) begin
              error_out  <= ERR_MAX;
              sample_en  <= 1'b1;
              cycle_slip <= 1'b1;
              n          <= '0;
              state      <= IDLE;
            end else begin
              n <= k;
            end
          end
          WAIT_REF: begin
            if (ref_edge) begin
              error_out <= signed'(err_lead);
              sample_en <= 1'b1;
              n         <= '0;
              state     <= fb_edge ? WAIT_REF : IDLE;
            end else if (fb_edge) begin
              error_out  <= ERR_MIN;
              sample_en  <= 1'b1;
              cycle_slip <= 1'b1;
              n          <= '0;
            end else if (k == TIMEOUT_K) begin
              error_out  <= ERR_MIN;
              sample_en  <= 1'b1;
              cycle_slip <= 1'b1;
              n          <= '0;
              state      <= IDLE;
            end else begin
              n <= k;
            end
          end
          default: begin
            state <= IDLE;
            n     <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/phase_detector.md
# phase_detector

Counting phase detector for the Tiny-PLL loop. It compares rising edges of the external reference input against rising edges of the DCO feedback signal. It measures their separation in `clk` cycles and emits one signed, saturated 4-bit error word per comparison, framed by a single-cycle strobe. Its outputs drive the loop filter's `error_in` / `sample_en` pair directly. Positive error means the feedback lags the reference, so the DCO must speed up.

## Interface
- `SYNC_STAGES`, default 2: synchronizer depth for `ref_in`. The `fb_in` path is delayed by the same depth so both paths have equal latency. Legal values: 2..4.
- `TIMEOUT`, default 31: maximum cycles to wait for the closing edge. Legal values: 7..255.
- `clk` input 1: system clock.
- `rst_n` input 1: reset, asynchronous, active-low.
- `enable` input 1: measurement enable. When low, the FSM is held in IDLE.
- `ref_in` input 1: reference clock. Asynchronous to `clk`.
- `fb_in` input 1: DCO feedback (accumulator MSB). Synchronous to `clk`.
- `error_out` output 4 (signed): measured phase error, range -7..+7.
- `sample_en` output 1: one-cycle strobe; `error_out` is valid while it is high.
- `cycle_slip` output 1: one-cycle pulse on a slip or timeout. Coincides with the `sample_en` of that event.

## Operation
- Edge detection:
  - `ref_in` passes through `SYNC_STAGES` flops; `fb_in` passes through `SYNC_STAGES` plain delay flops.
  - A rising edge is detected when the current stage output is 1 and the previous sample is 0.
  - Edge-history flops update regardless of `enable`.
- FSM states: IDLE, WAIT_FB (the reference opened the measurement), WAIT_REF (the feedback opened it). An 8-bit counter `n` holds the cycles elapsed since the opening edge.
- IDLE transitions:
  - ref edge only → WAIT_FB, n=0.
  - fb edge only → WAIT_REF, n=0.
  - Both edges in the same cycle → emit 0, stay in IDLE.
- WAIT_FB:
  - n increments every cycle.
  - On an fb edge at elapsed count k (k ≥ 1), emit +min(k,7) and go to IDLE.
  - If a ref edge arrives in that same cycle, emit the result above, then go to WAIT_FB with n=0.
- WAIT_REF: mirror of WAIT_FB. The closing ref edge emits -min(k,7).
- Slip:
  - A second ref edge in WAIT_FB emits +7, pulses `cycle_slip`, restarts n=0 and stays in WAIT_FB.
  - A second fb edge in WAIT_REF is the mirror case and emits -7.
- Timeout: if k reaches `TIMEOUT` with no closing edge, emit ±7 with the sign of the open state, pulse `cycle_slip`, and go to IDLE.
- `enable` deasserted in any state: go to IDLE on the next edge of `clk`. The pending measurement is discarded with no strobe.
- Saturation: the magnitude is clamped to 7. -8 is never produced.

## Timing
- Reset values: `error_out`=0, `sample_en`=0, `cycle_slip`=0, state IDLE, n=0, all sync and delay flops 0.
- `error_out`, `sample_en` and `cycle_slip` are registered. The strobe is asserted in the cycle after the closing-edge detection cycle.
- `error_out` holds its last value between strobes.
- From an input pin edge to detection takes `SYNC_STAGES`+1 cycles on both paths, so the measured k equals the true pin separation in cycles, within ±1 cycle of `ref_in` sync uncertainty.
- At most one `sample_en` is issued per cycle. Strobes can be back-to-back, for example during repeated slips.
- When `rst_n` is asserted mid-measurement, all outputs are forced to reset values immediately. No strobe is issued after release until a fresh edge pair arrives.

## Configuration
- `PHASE_DET_DEADZONE_EN`:
  - Defined: a closing edge with k=1 emits 0 instead of ±1, suppressing dither from the ±1-cycle sync jitter. The strobe still fires.
  - Undefined: k=1 emits ±1.
  - Slip, timeout and coincident-edge behaviour are identical either way.

## Test plan
- Coincident edges: `ref_in` and `fb_in` rise together every 40 cycles → one strobe per period, `error_out`=0, `cycle_slip`=0.
- Feedback lags: `fb_in` rises 3 cycles after `ref_in` → strobe with `error_out`=+3. At 12 cycles → +7, no `cycle_slip`.
- Feedback leads: `fb_in` rises 5 cycles before `ref_in` → `error_out`=-5.
- Lost feedback: `ref_in` toggling, `fb_in` stuck low, `TIMEOUT`=31 → strobe with +7 and `cycle_slip` 31 cycles after each detected ref edge.
- Slip: two ref edges 10 cycles apart, then fb → `error_out`=+7 with `cycle_slip` at the second ref edge, then the normal result measured from the second ref edge.
- Reset/enable abort and deadzone:
  - Drop `enable` (or assert `rst_n` low) during WAIT_FB → no strobe, outputs at reset values for `rst_n`.
  - k=1 → `error_out`=0 with `PHASE_DET_DEADZONE_EN` defined, +1 without.
